// File: rtl/tt_sram_bridge_if.sv
// Byte-stream handshake bundle between a TT user project and tt_sram_bridge.
// master = TT project side, slave = bridge side.
interface tt_sram_bridge_if;
  logic [7:0] tt_data;
  logic       tt_valid;
  logic       tt_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (
    output tt_data, tt_valid, rsp_ready,
    input  tt_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  tt_data, tt_valid, rsp_ready,
    output tt_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/tt_sram_bridge.sv
// Byte-serial command bridge (cmd, address bytes, data bytes) to a single-port SRAM.
// Optional macro TT_SRAM_BRIDGE_WR_ACK_EN adds a 0xA5 response byte after each write burst.
module tt_sram_bridge #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sram_bridge_if.slave    tt_bus,
  output logic [ADDR_W-1:0]  sram_addr_o,
  output logic [DATA_W-1:0]  sram_bm_o,
  output logic [DATA_W-1:0]  sram_din_o,
  output logic               sram_wen_o,
  output logic               sram_ren_o,
  output logic               sram_men_o,
  input  logic [DATA_W-1:0]  sram_dout_i,
  output logic               busy_o
);

  localparam int         NB         = DATA_W / 8;
  localparam int         ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam logic [1:0] LAST_ADDR  = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] LAST_DATA  = 2'(NB - 1);
  localparam logic [1:0] LAST_LAT   = 2'(READ_LAT - 1);
  localparam logic [7:0] ACK_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_RDATA
`ifdef TT_SRAM_BRIDGE_WR_ACK_EN
    , S_ACK
`endif
  } state_t;

  state_t            state_q,      state_d;
  logic              is_wr_q,      is_wr_d;
  logic [2:0]        words_left_q, words_left_d;
  logic [NB-1:0]     mask_q,       mask_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] buf_q,        buf_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [1:0]        lat_cnt_q,    lat_cnt_d;

  logic [4:0]        sh8;
  logic [15:0]       addr_ins;
  logic [DATA_W-1:0] buf_ins;
  logic [DATA_W-1:0] bm_exp;
  logic [7:0]        rsp_data;
  logic              rsp_valid;

  // Byte insertion points for the address accumulator and the word buffer.
  assign sh8      = {byte_cnt_q, 3'b000};
  assign addr_ins = (16'(addr_q) & ~(16'h00FF << sh8)) | (16'(tt_bus.tt_data) << sh8);
  assign buf_ins  = (buf_q & ~(DATA_W'(8'hFF) << sh8)) | (DATA_W'(tt_bus.tt_data) << sh8);

  always_comb begin
    for (int l = 0; l < NB; l++) begin
      bm_exp[l*8 +: 8] = {8{mask_q[l]}};
    end
  end

  assign tt_bus.tt_ready  = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign tt_bus.rsp_data  = rsp_data;
  assign tt_bus.rsp_valid = rsp_valid;
  assign busy_o           = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    words_left_d = words_left_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    byte_cnt_d   = byte_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    rsp_data     = 8'h00;
    rsp_valid    = 1'b0;
    sram_addr_o  = '0;
    sram_bm_o    = '0;
    sram_din_o   = '0;
    sram_wen_o   = 1'b0;
    sram_ren_o   = 1'b0;
    sram_men_o   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tt_bus.tt_valid) begin
          is_wr_d      = tt_bus.tt_data[7];
          words_left_d = tt_bus.tt_data[6:4];
          mask_d       = tt_bus.tt_data[NB-1:0];
          byte_cnt_d   = 2'd0;
          state_d      = S_ADDR;
        end
      end

      S_ADDR: begin
        if (tt_bus.tt_valid) begin
          addr_d = addr_ins[ADDR_W-1:0];
          if (byte_cnt_q == LAST_ADDR) begin
            byte_cnt_d = 2'd0;
            state_d    = is_wr_q ? S_WDATA : S_READ;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WDATA: begin
        if (tt_bus.tt_valid) begin
          buf_d = buf_ins;
          if (byte_cnt_q == LAST_DATA) begin
            byte_cnt_d = 2'd0;
            state_d    = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        sram_men_o  = 1'b1;
        sram_wen_o  = 1'b1;
        sram_addr_o = addr_q;
        sram_bm_o   = bm_exp;
        sram_din_o  = buf_q;
        if (words_left_q != 3'd0) begin
          words_left_d = words_left_q - 3'd1;
          addr_d       = addr_q + ADDR_W'(1);
          state_d      = S_WDATA;
        end else begin
`ifdef TT_SRAM_BRIDGE_WR_ACK_EN
          state_d = S_ACK;
`else
          state_d = S_IDLE;
`endif
        end
      end

      S_READ: begin
        sram_men_o  = 1'b1;
        sram_ren_o  = 1'b1;
        sram_addr_o = addr_q;
        sram_bm_o   = '1;
        lat_cnt_d   = 2'd0;
        state_d     = S_RWAIT;
      end

      S_RWAIT: begin
        if (lat_cnt_q == LAST_LAT) begin
          buf_d      = sram_dout_i;
          byte_cnt_d = 2'd0;
          state_d    = S_RDATA;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      S_RDATA: begin
        rsp_valid = 1'b1;
        rsp_data  = 8'(buf_q >> sh8);
        if (tt_bus.rsp_ready) begin
          if (byte_cnt_q == LAST_DATA) begin
            // The next read strobe waits until the last byte of this word is taken.
            byte_cnt_d = 2'd0;
            if (words_left_q != 3'd0) begin
              words_left_d = words_left_q - 3'd1;
              addr_d       = addr_q + ADDR_W'(1);
              state_d      = S_READ;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

`ifdef TT_SRAM_BRIDGE_WR_ACK_EN
      S_ACK: begin
        rsp_valid = 1'b1;
        rsp_data  = ACK_BYTE;
        if (tt_bus.rsp_ready) state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from state_q, so asserting rst_n drops them in the same instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= S_IDLE;
      is_wr_q      <= 1'b0;
      words_left_q <= 3'd0;
      mask_q       <= '0;
      addr_q       <= '0;
      buf_q        <= '0;
      byte_cnt_q   <= 2'd0;
      lat_cnt_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      words_left_q <= words_left_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      byte_cnt_q   <= byte_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_tt_sram_bridge.sv
// Directed self-checking bench for tt_sram_bridge with a behavioural READ_LAT=1 SRAM.
// Honours TT_SRAM_BRIDGE_WR_ACK_EN by expecting the 0xA5 byte after each write burst.
module tb_tt_sram_bridge;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 1;
  localparam int TMO      = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sram_bridge_if bus ();

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_bm, sram_din, sram_dout;
  logic              sram_wen, sram_ren, sram_men, busy;

  tt_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tt_bus      (bus),
    .sram_addr_o (sram_addr),
    .sram_bm_o   (sram_bm),
    .sram_din_o  (sram_din),
    .sram_wen_o  (sram_wen),
    .sram_ren_o  (sram_ren),
    .sram_men_o  (sram_men),
    .sram_dout_i (sram_dout),
    .busy_o      (busy)
  );

  // Behavioural SRAM: masked write, one-cycle registered read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    sram_dout = '0;
  end
  always @(posedge clk) begin
    if (sram_men && sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
    if (sram_men && sram_ren) sram_dout <= mem[sram_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] bm;
    logic [DATA_W-1:0] din;
    int                cyc;
  } wr_ev_t;

  wr_ev_t     wr_log [$];
  logic [7:0] rx_q [$];
  int cyc = 0;
  int ren_cnt = 0;
  int both_cnt = 0;
  int last_acc_cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_wen) wr_log.push_back('{sram_addr, sram_bm, sram_din, cyc});
    if (sram_ren) ren_cnt++;
    if (sram_wen && sram_ren) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.tt_data  = b;
    bus.tt_valid = 1'b1;
    while (bus.tt_ready !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      n_checks++;
      $display("FAIL tt_accept: tt_ready=%b required 1 within %0d cycles", bus.tt_ready, TMO);
    end
    @(negedge clk);
    bus.tt_valid = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic send_cmd_addr(input logic [7:0] cmd, input logic [15:0] addr);
    send_byte(cmd);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic recv_byte();
    int t = 0;
    bus.rsp_ready = 1'b1;
    while (bus.rsp_valid !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      n_checks++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within %0d cycles", bus.rsp_valid, TMO);
      rx_q.push_back(8'h00);
    end else begin
      rx_q.push_back(bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic finish_write();
`ifdef TT_SRAM_BRIDGE_WR_ACK_EN
    rx_q.delete();
    recv_byte();
    n_checks++;
    if (rx_q[0] !== 8'hA5) $display("FAIL wr_ack: got %h required a5", rx_q[0]);
    else n_pass++;
    @(negedge clk);
`else
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL wr_done: rsp_valid=%b busy=%b required 0 0", bus.rsp_valid, busy);
    else n_pass++;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_outputs(input string tag);
    logic [ADDR_W+2*DATA_W+2:0] sv;
    sv = {sram_addr, sram_bm, sram_din, sram_wen, sram_ren, sram_men};
    n_checks++;
    if (bus.tt_ready !== 1'b1) $display("FAIL %s tt_ready: got %b required 1", tag, bus.tt_ready);
    else n_pass++;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00)
      $display("FAIL %s rsp: valid=%b data=%h required 0 00", tag, bus.rsp_valid, bus.rsp_data);
    else n_pass++;
    n_checks++;
    if (sv !== '0) $display("FAIL %s sram_outputs: got %h required 0", tag, sv);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s busy: got %b required 0", tag, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.tt_data = 8'h00; bus.tt_valid = 1'b0; bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_write_full();
    int n0 = wr_log.size();
    int r0 = ren_cnt;
    int acc;
    send_cmd_addr(8'h8F, 16'h0005);
    send_word(32'hDEADBEEF);
    acc = last_acc_cyc;
    finish_write();
    n_checks++;
    if (wr_log.size() != n0 + 1) $display("FAIL wr_full_count: got %0d required %0d", wr_log.size() - n0, 1);
    else begin
      n_pass++;
      n_checks++;
      if (wr_log[n0].addr !== 10'h005 || wr_log[n0].bm !== 32'hFFFFFFFF || wr_log[n0].din !== 32'hDEADBEEF)
        $display("FAIL wr_full_fields: addr=%h bm=%h din=%h required 005 ffffffff deadbeef",
                 wr_log[n0].addr, wr_log[n0].bm, wr_log[n0].din);
      else n_pass++;
      n_checks++;
      if (wr_log[n0].cyc != acc) $display("FAIL wr_latency: strobe cycle %0d required %0d", wr_log[n0].cyc, acc);
      else n_pass++;
    end
    n_checks++;
    if (ren_cnt != r0) $display("FAIL wr_no_ren: got %0d ren pulses required 0", ren_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_read_single();
    logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int r0 = ren_cnt;
    int acc, t, first;
    rx_q.delete();
    send_cmd_addr(8'h00, 16'h0005);
    acc = last_acc_cyc;
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    first = cyc;
    n_checks++;
    if (first != acc + READ_LAT + 1) $display("FAIL rd_latency: first rsp cycle %0d required %0d", first, acc + READ_LAT + 1);
    else n_pass++;
    for (int i = 0; i < 4; i++) recv_byte();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) $display("FAIL rd_single_byte%0d: got %h required %h", i, rx_q[i], exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (ren_cnt != r0 + 1) $display("FAIL rd_single_ren: got %0d pulses required 1", ren_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_partial();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'hAD, 8'hDE};
    int n0 = wr_log.size();
    send_cmd_addr(8'h83, 16'h0005);
    send_word(32'h11223344);
    finish_write();
    send_cmd_addr(8'h80, 16'h0005);
    send_word(32'hFFFFFFFF);
    finish_write();
    n_checks++;
    if (wr_log.size() != n0 + 2) $display("FAIL partial_count: got %0d required 2", wr_log.size() - n0);
    else begin
      n_pass++;
      n_checks++;
      if (wr_log[n0].bm !== 32'h0000FFFF || wr_log[n0].din !== 32'h11223344)
        $display("FAIL partial_bm: bm=%h din=%h required 0000ffff 11223344", wr_log[n0].bm, wr_log[n0].din);
      else n_pass++;
      n_checks++;
      if (wr_log[n0+1].bm !== 32'h00000000 || wr_log[n0+1].addr !== 10'h005)
        $display("FAIL mask0_write: bm=%h addr=%h required 00000000 005", wr_log[n0+1].bm, wr_log[n0+1].addr);
      else n_pass++;
    end
    rx_q.delete();
    send_cmd_addr(8'h00, 16'h0005);
    for (int i = 0; i < 4; i++) recv_byte();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) $display("FAIL partial_rd_byte%0d: got %h required %h", i, rx_q[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_burst_wrap();
    logic [31:0]       w  [3] = '{32'h01020304, 32'hA0B0C0D0, 32'h5A6B7C8D};
    logic [ADDR_W-1:0] ea [3] = '{10'h3FF, 10'h000, 10'h001};
    int n0 = wr_log.size();
    int r0 = ren_cnt;
    send_cmd_addr(8'hAF, 16'h03FF);
    for (int i = 0; i < 3; i++) send_word(w[i]);
    finish_write();
    n_checks++;
    if (wr_log.size() != n0 + 3) $display("FAIL burst_wr_count: got %0d required 3", wr_log.size() - n0);
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_log[n0+i].addr !== ea[i] || wr_log[n0+i].din !== w[i])
          $display("FAIL burst_wr%0d: addr=%h din=%h required %h %h", i, wr_log[n0+i].addr, wr_log[n0+i].din, ea[i], w[i]);
        else n_pass++;
      end
    end
    rx_q.delete();
    send_cmd_addr(8'h20, 16'h03FF);
    for (int i = 0; i < 12; i++) recv_byte();
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (rx_q[i] !== w[i/4][(i%4)*8 +: 8]) $display("FAIL burst_rd_byte%0d: got %h required %h", i, rx_q[i], w[i/4][(i%4)*8 +: 8]);
      else n_pass++;
    end
    n_checks++;
    if (ren_cnt != r0 + 3) $display("FAIL burst_rd_ren: got %0d pulses required 3", ren_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [8] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'hD0, 8'hC0, 8'hB0, 8'hA0};
    int r0 = ren_cnt;
    int bad = 0;
    rx_q.delete();
    send_cmd_addr(8'h10, 16'h03FF);
    recv_byte();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h03) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles, rsp_data=%h required 03 held", bad, bus.rsp_data);
    else n_pass++;
    n_checks++;
    if (ren_cnt != r0 + 1) $display("FAIL bp_no_early_ren: got %0d pulses required 1", ren_cnt - r0);
    else n_pass++;
    for (int i = 1; i < 8; i++) recv_byte();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) $display("FAIL bp_byte%0d: got %h required %h", i, rx_q[i], exp[i]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (ren_cnt != r0 + 2 || busy !== 1'b0)
      $display("FAIL bp_end: ren pulses %0d busy=%b required 2 0", ren_cnt - r0, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    int n0 = wr_log.size();
    send_cmd_addr(8'hAF, 16'h0010);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_log.size() != n0) $display("FAIL reset_mid_no_wen: got %0d write strobes required 0", wr_log.size() - n0);
    else n_pass++;
    send_cmd_addr(8'h8F, 16'h0010);
    send_word(32'hCAFEF00D);
    finish_write();
    n_checks++;
    if (wr_log.size() != n0 + 1 || wr_log[wr_log.size()-1].addr !== 10'h010 || wr_log[wr_log.size()-1].din !== 32'hCAFEF00D)
      $display("FAIL post_reset_wr: count=%0d required 1 at addr 010 din cafef00d", wr_log.size() - n0);
    else n_pass++;
    rx_q.delete();
    send_cmd_addr(8'h00, 16'h0010);
    for (int i = 0; i < 4; i++) recv_byte();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_q[i] !== exp[i]) $display("FAIL post_reset_rd_byte%0d: got %h required %h", i, rx_q[i], exp[i]);
      else n_pass++;
    end
    n_checks++;
    if (both_cnt != 0) $display("FAIL wen_ren_overlap: got %0d cycles required 0", both_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_full();
    test_read_single();
    test_partial();
    test_burst_wrap();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
